uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr_pick4.sv | 23 ++
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM state encodings and watchdog default
// for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } state_e;

    // One second of watchdog at the 50 MHz system clock.
    localparam int unsigned TIMEOUT_MAX_DEFAULT = 32'd50_000_000 - 32'd1;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin pick; the first set request
// found scanning ptr, ptr+1, ... (mod 4) wins.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant_onehot,
    output logic [1:0] grant_idx
);

    logic [1:0] idx;

    // Scanning from the farthest offset down lets the nearest hit overwrite.
    always_comb begin
        idx       = '0;
        grant_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) grant_idx = idx;
        end
        grant_onehot = (req != 4'd0) ? 4'b0001 << grant_idx : 4'd0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter handing one byte at a time from
// N_REQ requesters to a byte transmitter, with a completion watchdog.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int          N_REQ       = 4,
    parameter int unsigned TIMEOUT_MAX = TIMEOUT_MAX_DEFAULT
) (
    input  logic               i_sysclk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]   o_grant,
    output logic [N_REQ-1:0]   o_ack,
    output logic               o_err,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_en,
    input  logic               i_tx_done,
    output logic               o_busy
);

    localparam int CW = (TIMEOUT_MAX > 0) ? $clog2(TIMEOUT_MAX + 1) : 1;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       gidx_q, gidx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [7:0]       data_q, data_d;
    logic             err_q, err_d;
    logic             tx_en_q, tx_en_d;
    logic             busy_q, busy_d;
    logic [3:0]       pick_oh;
    logic [1:0]       pick_idx;
    logic             launch;
    logic             done;
    logic             timeout;

    rr_pick4 u_pick (
        .req          (i_req),
        .ptr          (ptr_q),
        .grant_onehot (pick_oh),
        .grant_idx    (pick_idx)
    );

    assign launch  = (state_q == IDLE) && (|i_req);
    // i_tx_done only means something while a byte is in flight.
    assign done    = (state_q == WAIT_DONE) && i_tx_done;
    assign timeout = cnt_q == CW'(TIMEOUT_MAX);

    always_ff @(posedge i_sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            tx_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            err_q   <= err_d;
            tx_en_q <= tx_en_d;
            busy_q  <= busy_d;
        end
    end

    // Watchdog is zero everywhere but WAIT_DONE, so it is clear on entry.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = '0;
        case (state_q)
            IDLE:      state_d = launch ? START : IDLE;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: begin
                state_d = done ? ACK : (timeout ? IDLE : WAIT_DONE);
                cnt_d   = cnt_q + 1'b1;
                ptr_d   = (done || timeout) ? gidx_q + 2'd1 : ptr_q;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = launch ? pick_oh : ((state_d == IDLE) ? '0 : grant_q);
        gidx_d  = launch ? pick_idx : gidx_q;
        data_d  = launch ? i_req_data[{pick_idx, 3'b000} +: 8] : data_q;
        tx_en_d = state_d == START;
        ack_d   = (state_d == ACK) ? grant_q : '0;
        err_d   = (state_q == WAIT_DONE) && (state_d == IDLE);
        busy_d  = state_d != IDLE;
    end

    assign o_grant   = grant_q;
    assign o_ack     = ack_q;
    assign o_err     = err_q;
    assign o_tx_data = data_q;
    assign o_tx_en   = tx_en_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of uart_tx_arbiter
// against a cycle-arithmetic transaction model.
module tb_uart_tx_arbiter;

    localparam int TMAX = 99;

    logic        i_sysclk   = 1'b0;
    logic        i_rst_n    = 1'b1;
    logic [3:0]  i_req      = '0;
    logic [31:0] i_req_data = '0;
    logic        i_tx_done  = 1'b0;
    logic [3:0]  o_grant;
    logic [3:0]  o_ack;
    logic        o_err;
    logic [7:0]  o_tx_data;
    logic        o_tx_en;
    logic        o_busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_MAX(TMAX)) dut (
        .i_sysclk   (i_sysclk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_req_data (i_req_data),
        .o_grant    (o_grant),
        .o_ack      (o_ack),
        .o_err      (o_err),
        .o_tx_data  (o_tx_data),
        .o_tx_en    (o_tx_en),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy)
    );

    always #5 i_sysclk = ~i_sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: a grant at edge n0 gives START in cycle n0 and
    // WAIT_DONE from n0+1, with watchdog count k = cycle-(n0+1).
    int         cyc      = 0;
    bit         m_busy   = 0;
    int         m_g      = 0;
    int         m_n0     = 0;
    int         m_ack_at = -1;
    int         m_err_at = -1;
    int         m_ptr    = 0;
    logic [7:0] m_data   = '0;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
        return 0;
    endfunction

    always @(negedge i_rst_n) begin
        m_busy   = 0;
        m_ptr    = 0;
        m_data   = '0;
        m_ack_at = -1;
        m_err_at = -1;
    end

    always @(posedge i_sysclk) if (i_rst_n) begin
        cyc++;
        if (!m_busy) begin
            if (i_req != 4'd0) begin
                m_g      = pick(i_req, m_ptr);
                m_data   = i_req_data[8*m_g +: 8];
                m_busy   = 1;
                m_n0     = cyc;
                m_ack_at = -1;
            end
        end else if (m_ack_at >= 0) begin
            if (cyc == m_ack_at + 1) m_busy = 0;
        end else if (cyc - 1 > m_n0) begin
            if (i_tx_done) begin
                m_ack_at = cyc;
                m_ptr    = (m_g + 1) % 4;
            end else if (cyc - 1 - (m_n0 + 1) == TMAX) begin
                m_busy   = 0;
                m_err_at = cyc;
                m_ptr    = (m_g + 1) % 4;
            end
        end
    end

    always @(negedge i_sysclk) if (i_rst_n && started) begin : cmp
        logic [3:0] eg;
        eg = m_busy ? 4'(1 << m_g) : 4'd0;
        chk("model grant", 32'(o_grant), 32'(eg));
        chk("model tx_en", 32'(o_tx_en), 32'(m_busy && cyc == m_n0));
        chk("model ack", 32'(o_ack), (m_busy && cyc == m_ack_at) ? 32'(eg) : 32'd0);
        chk("model err", 32'(o_err), 32'(cyc == m_err_at));
        chk("model busy", 32'(o_busy), 32'(m_busy));
        chk("model tx_data", 32'(o_tx_data), 32'(m_data));
    end

    task automatic wait_tx_en(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_sysclk);
            if (o_tx_en) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_tx_en: no start pulse within 300 cycles");
        end
    endtask

    task automatic serve(input int d);
        repeat (d) @(negedge i_sysclk);
        i_tx_done = 1'b1;
        @(negedge i_sysclk);
        i_tx_done = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_sysclk);
        i_rst_n    = 1'b0;
        i_req      = '0;
        i_tx_done  = 1'b0;
        i_req_data = '0;
        repeat (2) @(negedge i_sysclk);
        i_rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " grant"}, 32'(o_grant), 32'd0);
        chk({name, " ack"}, 32'(o_ack), 32'd0);
        chk({name, " err"}, 32'(o_err), 32'd0);
        chk({name, " tx_data"}, 32'(o_tx_data), 32'd0);
        chk({name, " tx_en"}, 32'(o_tx_en), 32'd0);
        chk({name, " busy"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        bit ok;
        int n;
        int exp_g[5] = '{0, 1, 2, 3, 0};

        #1 i_rst_n = 1'b0;
        repeat (2) @(negedge i_sysclk);
        chk_all_zero("reset");
        i_rst_n = 1'b1;
        started = 1;

        // Single request
        i_req      = 4'b0001;
        i_req_data = 32'h0000_0055;
        wait_tx_en(ok);
        chk("single tx_data", 32'(o_tx_data), 32'h55);
        chk("single grant", 32'(o_grant), 32'b0001);
        i_req = '0;
        serve(10);
        chk("single ack", 32'(o_ack), 32'b0001);
        chk("single busy in ack", 32'(o_busy), 32'd1);
        @(negedge i_sysclk);
        chk("single ack cleared", 32'(o_ack), 32'd0);
        chk("single busy falls", 32'(o_busy), 32'd0);

        // Contention
        do_reset();
        i_req      = 4'b1111;
        i_req_data = 32'hA3A2_A1A0;
        for (int r = 0; r < 5; r++) begin
            wait_tx_en(ok);
            chk("contention grant", 32'(o_grant), 32'(4'b0001 << exp_g[r]));
            chk("contention tx_data", 32'(o_tx_data), 32'(8'hA0 + exp_g[r]));
            if (r == 4) i_req = '0;
            serve(3);
            chk("contention ack", 32'(o_ack), 32'(4'b0001 << exp_g[r]));
        end

        // Fairness: after serving requester 1, requester 0 goes first
        do_reset();
        i_req      = 4'b0010;
        i_req_data = 32'h0000_2211;
        wait_tx_en(ok);
        chk("fair first grant", 32'(o_grant), 32'b0010);
        serve(2);
        i_req = 4'b0011;
        chk("fair first ack", 32'(o_ack), 32'b0010);
        wait_tx_en(ok);
        chk("fair grant0", 32'(o_grant), 32'b0001);
        serve(2);
        chk("fair ack0", 32'(o_ack), 32'b0001);
        wait_tx_en(ok);
        chk("fair grant1", 32'(o_grant), 32'b0010);
        i_req = '0;
        serve(2);
        chk("fair ack1", 32'(o_ack), 32'b0010);

        // Watchdog timeout
        do_reset();
        i_req      = 4'b0011;
        i_req_data = 32'h0000_BBAA;
        wait_tx_en(ok);
        chk("timeout grant", 32'(o_grant), 32'b0001);
        n = 0;
        while (n < 200) begin
            @(negedge i_sysclk);
            n++;
            chk("timeout no ack", 32'(o_ack), 32'd0);
            if (o_err) break;
        end
        chk("timeout err delay", 32'(n - 1), 32'd100);
        chk("timeout grant cleared", 32'(o_grant), 32'd0);
        wait_tx_en(ok);
        chk("timeout next grant", 32'(o_grant), 32'b0010);
        chk("timeout next data", 32'(o_tx_data), 32'hBB);
        i_req = '0;
        serve(2);
        chk("timeout next ack", 32'(o_ack), 32'b0010);

        // Reset mid-transfer
        do_reset();
        i_req      = 4'b0100;
        i_req_data = 32'h005A_0000;
        wait_tx_en(ok);
        @(negedge i_sysclk);
        #2 i_rst_n = 1'b0;
        #1 chk_all_zero("async reset");
        i_req_data = 32'h0077_0000;
        @(negedge i_sysclk);
        i_rst_n = 1'b1;
        wait_tx_en(ok);
        chk("post reset grant", 32'(o_grant), 32'b0100);
        chk("post reset data", 32'(o_tx_data), 32'h77);
        i_req = '0;
        serve(2);
        chk("post reset ack", 32'(o_ack), 32'b0100);

        // Data stability across WAIT_DONE, dropped request still acked
        do_reset();
        i_req      = 4'b0001;
        i_req_data = 32'h0000_003C;
        wait_tx_en(ok);
        @(negedge i_sysclk);
        i_req_data = 32'hFFFF_FFFF;
        i_req      = '0;
        repeat (5) begin
            @(negedge i_sysclk);
            chk("stable tx_data", 32'(o_tx_data), 32'h3C);
            chk("stable grant", 32'(o_grant), 32'b0001);
        end
        serve(1);
        chk("stable ack", 32'(o_ack), 32'b0001);
        @(negedge i_sysclk);
        chk("stable data after", 32'(o_tx_data), 32'h3C);
        chk("stable idle", 32'(o_busy), 32'd0);

        // Randomized traffic, including spurious and missing done pulses
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge i_sysclk);
            if ($urandom_range(0, 7) == 0) i_req = 4'($urandom);
            if ($urandom_range(0, 15) == 0) i_req_data = $urandom;
            i_tx_done = ($urandom_range(0, 29) == 0);
        end
        i_req     = '0;
        i_tx_done = 1'b0;
        repeat (150) @(negedge i_sysclk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
